// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM.
// Each accepted instruction walks IDLE -> DECODE -> EXEC -> WB -> IDLE.
// The word is captured into IR when it is accepted. All outputs are registered:
//   - datapath controls hold their values from EXEC entry through WB;
//   - strobes (regWrite, jumpEN, jalEN, pc_inc, done) are high only in WB.
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid && instr_ready. instr_ready is high only while the FSM is in IDLE,
// so instr_valid seen in any other state is dropped, never queued. The upstream
// side need not hold instr stable after that edge.
module control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               regWrite,
    output logic               shiftOrALU,
    output logic               alusrca,
    output logic               alusrcb,
    output logic [3:0]         aluControl,
    output logic [REGBITS-1:0] regAddress1,
    output logic [REGBITS-1:0] regAddress2,
    output logic [WIDTH-1:0]   immediate,
    output logic               shiftType,
    output logic [WIDTH-1:0]   shiftDirection,
    output logic               jumpEN,
    output logic               jalEN,
    output logic [WIDTH-1:0]   RTarget,
    output logic               pc_inc,
    output logic               done,
    output logic               illegal,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ir;

    // Instruction fields taken from the latched IR.
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [7:0] imm8;

    assign op    = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign rsrc  = ir[3:0];
    assign imm8  = ir[7:0];

    // Decoded control values, loaded into the output registers on entry to EXEC/WB.
    logic             d_legal;
    logic             d_write;
    logic             d_jump;
    logic             d_jal;
    logic             d_srca;
    logic             d_srcb;
    logic             d_sor;
    logic [3:0]       d_alu;
    logic [WIDTH-1:0] d_imm;
    logic             d_stype;
    logic [WIDTH-1:0] d_sdir;
    logic [WIDTH-1:0] shamt;

    // Zero-extended 4-bit shift amount for the LSHI form.
    assign shamt = {{(WIDTH-4){1'b0}}, rsrc};

    // Debug view of the FSM state.
    assign fsm_state = state;

    // Indirect jump targets come through regAddress2, so RTarget stays zero.
    assign RTarget = '0;

    // Decode the latched instruction into control values.
    always_comb begin
        d_legal = 1'b0;
        d_write = 1'b0;
        d_jump  = 1'b0;
        d_jal   = 1'b0;
        d_srca  = 1'b0;
        d_srcb  = 1'b0;
        d_sor   = 1'b0;
        d_alu   = 4'd0;
        d_imm   = '0;
        d_stype = 1'b0;
        d_sdir  = '0;
        if (op == 4'b0000 && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})) begin
            // Register-register ALU op; CMP (1011) only sets flags.
            d_legal = 1'b1;
            d_alu   = ext;
            d_srca  = 1'b1;
            d_sor   = 1'b1;
            d_write = (ext != 4'hB);
        end else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
            // Immediate ALU op: arithmetic forms sign-extend, logical/move forms zero-extend.
            d_legal = 1'b1;
            d_alu   = op;
            d_srca  = 1'b1;
            d_srcb  = 1'b1;
            d_sor   = 1'b1;
            d_write = (op != 4'hB);
            if (op inside {4'h5, 4'h9, 4'hB})
                d_imm = {{(WIDTH-8){imm8[7]}}, imm8};
            else
                d_imm = {{(WIDTH-8){1'b0}}, imm8};
        end else if (op == 4'b1000) begin
            // Shifter ops; register forms leave shiftDirection at zero.
            if (ext == 4'b0100) begin
                d_legal = 1'b1;
                d_write = 1'b1;
            end else if (ext == 4'b0110) begin
                d_legal = 1'b1;
                d_write = 1'b1;
                d_stype = 1'b1;
            end else if (ext[3:1] == 3'b000) begin
                d_legal = 1'b1;
                d_write = 1'b1;
                d_sdir  = ext[0] ? (~shamt + 1'b1) : shamt;
            end
        end else if (op == 4'b0100) begin
            // JUC jumps only; JAL also writes the link register Rdest.
            if (ext == 4'b1100) begin
                d_legal = 1'b1;
                d_jump  = 1'b1;
            end else if (ext == 4'b1000) begin
                d_legal = 1'b1;
                d_jump  = 1'b1;
                d_jal   = 1'b1;
                d_write = 1'b1;
            end
        end
    end

    // State sequencing, IR capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ir             <= '0;
            instr_ready    <= 1'b1;
            illegal        <= 1'b0;
            regWrite       <= 1'b0;
            jumpEN         <= 1'b0;
            jalEN          <= 1'b0;
            pc_inc         <= 1'b0;
            done           <= 1'b0;
            shiftOrALU     <= 1'b0;
            alusrca        <= 1'b0;
            alusrcb        <= 1'b0;
            aluControl     <= 4'd0;
            regAddress1    <= '0;
            regAddress2    <= '0;
            immediate      <= '0;
            shiftType      <= 1'b0;
            shiftDirection <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    state          <= EXEC;
                    shiftOrALU     <= d_sor;
                    alusrca        <= d_srca;
                    alusrcb        <= d_srcb;
                    aluControl     <= d_alu;
                    regAddress1    <= d_legal ? REGBITS'(rdest) : '0;
                    regAddress2    <= d_legal ? REGBITS'(rsrc) : '0;
                    immediate      <= d_imm;
                    shiftType      <= d_stype;
                    shiftDirection <= d_sdir;
                end
                EXEC: begin
                    state    <= WB;
                    regWrite <= d_write;
                    jumpEN   <= d_jump;
                    jalEN    <= d_jal;
                    pc_inc   <= d_legal && !d_jump;
                    done     <= 1'b1;
                    if (!d_legal)
                        illegal <= 1'b1;
                end
                WB: begin
                    state          <= IDLE;
                    instr_ready    <= 1'b1;
                    regWrite       <= 1'b0;
                    jumpEN         <= 1'b0;
                    jalEN          <= 1'b0;
                    pc_inc         <= 1'b0;
                    done           <= 1'b0;
                    shiftOrALU     <= 1'b0;
                    alusrca        <= 1'b0;
                    alusrcb        <= 1'b0;
                    aluControl     <= 4'd0;
                    regAddress1    <= '0;
                    regAddress2    <= '0;
                    immediate      <= '0;
                    shiftType      <= 1'b0;
                    shiftDirection <= '0;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: a behavioural model tracks the instruction phase and
// computes the expected outputs from the instruction semantics. A per-cycle
// compare process checks the DUT against this model, and directed literal checks
// pin known encodings.
module tb_control_fsm;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, regWrite, shiftOrALU, alusrca, alusrcb;
    logic [3:0]  aluControl, regAddress1, regAddress2;
    logic [15:0] immediate, shiftDirection, RTarget;
    logic        shiftType, jumpEN, jalEN, pc_inc, done, illegal;
    logic [1:0]  fsm_state;

    control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .regWrite(regWrite), .shiftOrALU(shiftOrALU),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluControl(aluControl),
        .regAddress1(regAddress1), .regAddress2(regAddress2), .immediate(immediate),
        .shiftType(shiftType), .shiftDirection(shiftDirection), .jumpEN(jumpEN),
        .jalEN(jalEN), .RTarget(RTarget), .pc_inc(pc_inc), .done(done),
        .illegal(illegal), .fsm_state(fsm_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        legal;
        logic        wr;
        logic        jmp;
        logic        jal;
        logic        srca;
        logic        srcb;
        logic        sor;
        logic [3:0]  alu;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [15:0] imm;
        logic        stype;
        logic [15:0] sdir;
    } exp_t;

    // Classify an instruction into a kind, then derive its controls from that kind.
    function automatic exp_t model_decode(input logic [15:0] w);
        logic [3:0] op  = w[15:12];
        logic [3:0] ext = w[7:4];
        int kind = 0;
        int v;
        exp_t e = '0;
        if (op == 0 && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})) kind = 1;
        else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})          kind = 2;
        else if (op == 8 && ext == 4)                                          kind = 3;
        else if (op == 8 && ext == 6)                                          kind = 4;
        else if (op == 8 && (ext == 0 || ext == 1))                            kind = 5;
        else if (op == 4 && ext == 12)                                         kind = 6;
        else if (op == 4 && ext == 8)                                          kind = 7;
        case (kind)
            1: begin e.alu = ext; e.srca = 1; e.sor = 1; e.wr = (ext != 11); end
            2: begin
                e.alu = op; e.srca = 1; e.srcb = 1; e.sor = 1; e.wr = (op != 11);
                if (op inside {4'h5, 4'h9, 4'hB}) v = int'($signed(w[7:0]));
                else v = int'(w[7:0]);
                e.imm = v[15:0];
            end
            3: e.wr = 1;
            4: begin e.wr = 1; e.stype = 1; end
            5: begin
                v = int'(w[3:0]);
                if (ext == 1) v = -v;
                e.sdir = v[15:0];
                e.wr = 1;
            end
            6: e.jmp = 1;
            7: begin e.jmp = 1; e.jal = 1; e.wr = 1; end
            default: ;
        endcase
        e.legal = (kind != 0);
        if (e.legal) begin
            e.a1 = w[11:8];
            e.a2 = w[3:0];
        end
        return e;
    endfunction

    // Phase 0..3 = waiting, decoding, executing, writing back.
    int          m_phase = 0;
    logic [15:0] m_ir = 16'h0;
    logic        m_ill = 1'b0;
    logic        m_on = 1'b0;

    // Advance the model on each rising edge from the inputs presented at that edge.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_ir = 16'h0; m_ill = 1'b0; m_on = 1'b1;
        end else if (m_on) begin
            if (m_phase == 0) begin
                if (instr_valid) begin m_ir = instr; m_phase = 1; end
            end else if (m_phase == 3) begin
                m_phase = 0;
            end else begin
                if (m_phase == 2 && !model_decode(m_ir).legal) m_ill = 1'b1;
                m_phase = m_phase + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_on) begin
            exp_t e, z;
            logic dp, wb;
            e  = model_decode(m_ir);
            z  = '0;
            dp = (m_phase == 2 || m_phase == 3);
            wb = (m_phase == 3);
            if (!dp) e = z;
            chk("instr_ready", instr_ready, m_phase == 0);
            chk("aluControl", aluControl, e.alu);
            chk("alusrca", alusrca, e.srca);
            chk("alusrcb", alusrcb, e.srcb);
            chk("shiftOrALU", shiftOrALU, e.sor);
            chk("regAddress1", regAddress1, e.a1);
            chk("regAddress2", regAddress2, e.a2);
            chk("immediate", immediate, e.imm);
            chk("shiftType", shiftType, e.stype);
            chk("shiftDirection", shiftDirection, e.sdir);
            chk("regWrite", regWrite, wb && e.wr);
            chk("jumpEN", jumpEN, wb && e.jmp);
            chk("jalEN", jalEN, wb && e.jal);
            chk("pc_inc", pc_inc, wb && e.legal && !e.jmp);
            chk("done", done, wb);
            chk("illegal", illegal, m_ill);
            chk("RTarget", RTarget, 0);
        end
    end

    // ---------------- driver tasks ----------------
    logic [3:0] alu_codes [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0] shf_codes [4] = '{4'h4, 4'h6, 4'h0, 4'h1};

    function automatic logic [15:0] rand_instr();
        int r = $urandom_range(0, 9);
        logic [15:0] w = 16'($urandom);
        case (r)
            0, 1, 2: begin w[15:12] = 4'h0; w[7:4] = alu_codes[$urandom_range(0, 6)]; end
            3, 4:    w[15:12] = alu_codes[$urandom_range(0, 6)];
            5:       begin w[15:12] = 4'h8; w[7:4] = shf_codes[$urandom_range(0, 3)]; end
            6:       begin w[15:12] = 4'h4; w[7:4] = ($urandom_range(0, 1) != 0) ? 4'hC : 4'h8; end
            default: ;
        endcase
        return w;
    endfunction

    // Random valid/instr while busy: must be ignored.
    task automatic garbage();
        instr_valid = ($urandom_range(0, 1) != 0);
        instr = 16'($urandom);
    endtask

    // Called at a negedge in IDLE; returns at the negedge inside EXEC.
    task automatic send(input logic [15:0] w);
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        garbage();
        @(negedge clk);
        garbage();
    endtask

    task automatic to_wb();
        @(negedge clk);
        garbage();
    endtask

    task automatic to_idle();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1; instr_valid = 1'b1; instr = 16'h0512;
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);

        reset = 1'b0;
        send(16'h0512);
        chk("and_alu", aluControl, 4'h1);
        chk("and_srca", alusrca, 1);
        chk("and_srcb", alusrcb, 0);
        chk("and_a1", regAddress1, 4'h5);
        chk("and_a2", regAddress2, 4'h2);
        to_wb();
        chk("and_wr", regWrite, 1);
        chk("and_pcinc", pc_inc, 1);
        chk("and_done", done, 1);
        to_idle();

        send(16'h53FF);
        chk("addi_imm", immediate, 16'hFFFF);
        chk("addi_srcb", alusrcb, 1);
        chk("addi_alu", aluControl, 4'h5);
        to_wb(); to_idle();

        send(16'h13FF);
        chk("andi_imm", immediate, 16'h00FF);
        to_wb(); to_idle();

        send(16'h8413);
        chk("lshi_sor", shiftOrALU, 0);
        chk("lshi_type", shiftType, 0);
        chk("lshi_dir", shiftDirection, 16'hFFFD);
        to_wb(); to_idle();

        send(16'h8403);
        chk("lshi_pos", shiftDirection, 16'h0003);
        to_wb(); to_idle();

        send(16'h4E87);
        to_wb();
        chk("jal_jump", jumpEN, 1);
        chk("jal_jal", jalEN, 1);
        chk("jal_wr", regWrite, 1);
        chk("jal_pcinc", pc_inc, 0);
        to_idle();

        send(16'h0AB7);
        to_wb();
        chk("cmp_wr", regWrite, 0);
        chk("cmp_pcinc", pc_inc, 1);
        to_idle();

        send(16'hF000);
        chk("ill_exec", illegal, 0);
        to_wb();
        chk("ill_wb", illegal, 1);
        chk("ill_wr", regWrite, 0);
        chk("ill_done", done, 1);
        to_idle();
        chk("ill_sticky", illegal, 1);

        // Reset in EXEC of an ADD.
        send(16'h0152);
        reset = 1'b1;
        @(negedge clk);
        chk("rexec_wr", regWrite, 0);
        chk("rexec_ill", illegal, 0);
        chk("rexec_ready", instr_ready, 1);
        chk("rexec_done", done, 0);
        reset = 1'b0; instr_valid = 1'b0;
        @(negedge clk);

        // Reset in WB.
        send(16'h0512);
        to_wb();
        reset = 1'b1;
        @(negedge clk);
        chk("rwb_wr", regWrite, 0);
        chk("rwb_pcinc", pc_inc, 0);
        chk("rwb_ready", instr_ready, 1);
        reset = 1'b0; instr_valid = 1'b0;
        @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr = rand_instr();
            @(negedge clk);
        end
        reset = 1'b0; instr_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
